core_control_fsm: RTL and testbench
===================================

Name: core_control_fsm

Overview:
- Multicycle sequencer of the core. Consumes the current instruction's opcode/funct3 from the instruction register/decoder.
- Drives the per-stage control enums: memory mode, branch ALU mode, immediate former mode, RD source select lines and instruction address source.
- Also drives the RD/PC write strobes, a sticky halt and a retired-instruction counter.
- Sits between the instruction decoder and the register file, ALUs and memory backend.

Parameters:
- MEM_LATENCY, 1, data-memory cycles per LOAD or STORE_PRELOAD access; legal range 1..8.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- opcode  in  7  Opcode_t of the current instruction; stable from the EXECUTE entry until commit.
- funct3  in  3  Funct3_t of the current instruction.
- memoryMode  out  2  MemoryMode_t.
- branchALUMode  out  2  BranchALUMode_t.
- immediateFormerMode  out  1  ImmediateFormerMode_t.
- rdSourceSelect  out  4  RDSourceSelectLines_t; one-hot or all zero.
- rdWriteEnable  out  1  register file write strobe.
- pcWriteEnable  out  1  PC update strobe; marks instruction retirement.
- instructionAddressSource  out  1  InstructionAddressSource_t.
- halted  out  1  sticky; set on ECALL/EBREAK/illegal.
- illegalInstruction  out  1  sticky; set on illegal opcode/funct3.
- instretCount  out  64  retired-instruction count.

Behaviour:
- States: FETCH, EXECUTE, MEM_WAIT, STORE_PRELOAD, STORE_COMMIT, HALT.
- Outputs are decoded combinationally from the registered state, the inputs and the latency counter.
- Any output not listed for a state takes its default: memoryMode=NOP, branchALUMode=INCREMENT, immediateFormerMode=LUI, rdSourceSelect=0, strobes=0, instructionAddressSource=CURRENT_PC.
- Reset: on any edge with reset=0, the block enters FETCH and clears the counter, halted, illegalInstruction and instretCount. This applies from any state, including mid-MEM_WAIT and HALT. In the following cycle all outputs take their defaults.

FETCH:
- One cycle; instruction memory read at CURRENT_PC.
- Next state: EXECUTE.

EXECUTE, by opcode:
- LUI 0110111 / AUIPC 0010111: immediate former output enable; immediateFormerMode=LUI or AUIPC; rdWriteEnable=1; pcWriteEnable=1.
- OP-IMM 0010011 / OP 0110011: ALU output enable; rdWriteEnable=1; pcWriteEnable=1.
- JAL 1101111 / JALR 1100111: branch ALU output enable; branchALUMode=JAL or JALR; rdWriteEnable=1; pcWriteEnable=1.
- BRANCH 1100011: branchALUMode=BRANCH; pcWriteEnable=1; no RD write.
- MISC-MEM 0001111: treated as a nop; pcWriteEnable=1.
- All of the above: instructionAddressSource=NEXT_PC; next state FETCH.
- LOAD 0000011: memoryMode=LOAD; counter loaded with MEM_LATENCY; next state MEM_WAIT.
- STORE 0100011: memoryMode=STORE_PRELOAD; counter loaded with MEM_LATENCY; next state STORE_PRELOAD.
- SYSTEM 1110011 with funct3=000: next state HALT; halted set.
- Any other opcode, SYSTEM with funct3≠000, or opcode[1:0]≠11: next state HALT; halted and illegalInstruction set.
- No strobes are asserted on any HALT transition.

MEM_WAIT:
- memoryMode=LOAD. Counter decrements each cycle.
- Commit cycle is when the counter equals 1: memory output enable, rdWriteEnable=1, pcWriteEnable=1, instructionAddressSource=NEXT_PC; next state FETCH.
- MEM_LATENCY=1 means exactly one MEM_WAIT cycle.

STORE_PRELOAD:
- memoryMode=STORE_PRELOAD. Same count rule; at count 1, next state STORE_COMMIT.

STORE_COMMIT:
- One cycle. memoryMode=STORE, pcWriteEnable=1, instructionAddressSource=NEXT_PC.
- Next state FETCH.

HALT:
- Absorbing until reset. All outputs at defaults; halted=1.

instretCount:
- Increments by 1 on each edge where pcWriteEnable=1.
- Wraps modulo 2^64.

Resulting cycles per instruction:
- Non-memory: 2.
- LOAD: 2+MEM_LATENCY.
- STORE: 3+MEM_LATENCY.

Decomposition:
- JZJCoreFTypes package gains:
  - ControlState_t enum (3-bit).
  - OPCODE_* localparam constants, so that names do not collide with the existing MemoryMode_t and BranchALUMode_t members.
  - SYSTEM funct3 constant.
- One combinational sub-module, opcode_classifier: maps opcode/funct3 to an instruction class (IMM_FORM, ALU, JUMP, BRANCH, NOP_CLASS, LOAD_CLASS, STORE_CLASS, HALT_CLASS, ILLEGAL).
- The FSM, counter and instret logic stay in core_control_fsm.

Test Plan:
- Reset released, opcode=0010011 (ADDI): cycle 0 FETCH defaults. Cycle 1 shows ALU output enable, rdWriteEnable=1, pcWriteEnable=1, NEXT_PC. instretCount=1 after the edge. The pattern repeats every 2 cycles.
- MEM_LATENCY=3, opcode=0000011: memoryMode=LOAD for 4 consecutive cycles (EXECUTE plus 3 MEM_WAIT). Strobes and memory output enable are asserted only in the 4th cycle. The next instruction's FETCH follows.
- MEM_LATENCY=1, opcode=0100011: STORE_PRELOAD for 2 cycles, then STORE for 1 cycle with pcWriteEnable=1. rdWriteEnable stays 0 throughout.
- opcode=1101111 then 1100011: JAL executes with branchALUMode=JAL, branch ALU output enable and rdWriteEnable=1. BRANCH executes with branchALUMode=BRANCH and rdWriteEnable=0. instretCount reaches 2.
- opcode=0000000: halted=1 and illegalInstruction=1 after EXECUTE and remain set for 20 cycles regardless of opcode; instretCount frozen. Repeat with opcode=1110011, funct3=000: halted=1, illegalInstruction=0.
- reset=0 for one edge during MEM_WAIT (MEM_LATENCY=4, second wait cycle): next cycle is FETCH with all defaults and instretCount=0. No rdWriteEnable pulse occurs for the aborted load.

Source files
------------

// File: rtl/core_control_fsm_pkg.sv
// Shared types and constants for the multicycle core control sequencer.
// Opcode constants carry an OPCODE_ prefix so they never clash with the mode enums.
package core_control_fsm_pkg;

  typedef logic [6:0] Opcode_t;
  typedef logic [2:0] Funct3_t;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  typedef enum logic [1:0] {
    INCREMENT = 2'd0,
    JAL       = 2'd1,
    JALR      = 2'd2,
    BRANCH    = 2'd3
  } BranchALUMode_t;

  typedef enum logic {
    LUI   = 1'b0,
    AUIPC = 1'b1
  } ImmediateFormerMode_t;

  typedef enum logic {
    CURRENT_PC = 1'b0,
    NEXT_PC    = 1'b1
  } InstructionAddressSource_t;

  typedef struct packed {
    logic memory_output_enable;
    logic branch_alu_output_enable;
    logic alu_output_enable;
    logic immediate_former_output_enable;
  } RDSourceSelectLines_t;

  typedef enum logic [3:0] {
    IMM_FORM     = 4'd0,
    ALU          = 4'd1,
    JUMP         = 4'd2,
    BRANCH_CLASS = 4'd3,
    NOP_CLASS    = 4'd4,
    LOAD_CLASS   = 4'd5,
    STORE_CLASS  = 4'd6,
    HALT_CLASS   = 4'd7,
    ILLEGAL      = 4'd8
  } InstrClass_t;

  typedef logic [2:0] ControlState_t;
  localparam ControlState_t STATE_FETCH         = 3'd0;
  localparam ControlState_t STATE_EXECUTE       = 3'd1;
  localparam ControlState_t STATE_MEM_WAIT      = 3'd2;
  localparam ControlState_t STATE_STORE_PRELOAD = 3'd3;
  localparam ControlState_t STATE_STORE_COMMIT  = 3'd4;
  localparam ControlState_t STATE_HALT          = 3'd5;

  localparam Opcode_t OPCODE_LUI      = 7'b0110111;
  localparam Opcode_t OPCODE_AUIPC    = 7'b0010111;
  localparam Opcode_t OPCODE_OP_IMM   = 7'b0010011;
  localparam Opcode_t OPCODE_OP       = 7'b0110011;
  localparam Opcode_t OPCODE_JAL      = 7'b1101111;
  localparam Opcode_t OPCODE_JALR     = 7'b1100111;
  localparam Opcode_t OPCODE_BRANCH   = 7'b1100011;
  localparam Opcode_t OPCODE_MISC_MEM = 7'b0001111;
  localparam Opcode_t OPCODE_LOAD     = 7'b0000011;
  localparam Opcode_t OPCODE_STORE    = 7'b0100011;
  localparam Opcode_t OPCODE_SYSTEM   = 7'b1110011;

  localparam Funct3_t FUNCT3_SYSTEM_PRIV = 3'b000;

endpackage

// File: rtl/core_control_fsm_opcode_classifier.sv
// Maps opcode/funct3 onto the instruction class the sequencer branches on.
module core_control_fsm_opcode_classifier
  import core_control_fsm_pkg::*;
(
  input  Opcode_t     opcode,
  input  Funct3_t     funct3,
  output InstrClass_t instr_class
);

  // Only the base-ISA opcodes are known; only ECALL/EBREAK are accepted from SYSTEM.
  always_comb begin
    instr_class = ILLEGAL;
    if (opcode[1:0] != 2'b11) begin
      instr_class = ILLEGAL;
    end else begin
      case (opcode)
        OPCODE_LUI, OPCODE_AUIPC:  instr_class = IMM_FORM;
        OPCODE_OP_IMM, OPCODE_OP:  instr_class = ALU;
        OPCODE_JAL, OPCODE_JALR:   instr_class = JUMP;
        OPCODE_BRANCH:             instr_class = BRANCH_CLASS;
        OPCODE_MISC_MEM:           instr_class = NOP_CLASS;
        OPCODE_LOAD:               instr_class = LOAD_CLASS;
        OPCODE_STORE:              instr_class = STORE_CLASS;
        OPCODE_SYSTEM: begin
          if (funct3 == FUNCT3_SYSTEM_PRIV) begin
            instr_class = HALT_CLASS;
          end else begin
            instr_class = ILLEGAL;
          end
        end
        default:                   instr_class = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/core_control_fsm.sv
// Multicycle control sequencer: FETCH/EXECUTE plus memory wait states, sticky halt
// and a 64-bit retired-instruction counter.
module core_control_fsm
  import core_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
)
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  output MemoryMode_t               memoryMode,
  output BranchALUMode_t            branchALUMode,
  output ImmediateFormerMode_t      immediateFormerMode,
  output RDSourceSelectLines_t      rdSourceSelect,
  output logic                      rdWriteEnable,
  output logic                      pcWriteEnable,
  output InstructionAddressSource_t instructionAddressSource,
  output logic                      halted,
  output logic                      illegalInstruction,
  output logic [63:0]               instretCount
);

  localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);

  ControlState_t state_r;
  ControlState_t next_state_s;
  logic [3:0]    count_r;
  logic          load_count_s;
  logic          set_halt_s;
  logic          set_illegal_s;
  logic          halted_r;
  logic          illegal_r;
  logic [63:0]   instret_r;
  InstrClass_t   instr_class_s;

  core_control_fsm_opcode_classifier u_classifier (
    .opcode      (opcode),
    .funct3      (funct3),
    .instr_class (instr_class_s)
  );

  // Output decode and next-state selection from the registered state.
  always_comb begin
    memoryMode               = NOP;
    branchALUMode            = INCREMENT;
    immediateFormerMode      = LUI;
    rdSourceSelect           = '0;
    rdWriteEnable            = 1'b0;
    pcWriteEnable            = 1'b0;
    instructionAddressSource = CURRENT_PC;
    next_state_s             = state_r;
    load_count_s             = 1'b0;
    set_halt_s               = 1'b0;
    set_illegal_s            = 1'b0;
    case (state_r)
      STATE_FETCH: next_state_s = STATE_EXECUTE;
      STATE_EXECUTE: begin
        case (instr_class_s)
          IMM_FORM: begin
            rdSourceSelect.immediate_former_output_enable = 1'b1;
            if (opcode == OPCODE_AUIPC) begin
              immediateFormerMode = AUIPC;
            end else begin
              immediateFormerMode = LUI;
            end
            rdWriteEnable = 1'b1;
            pcWriteEnable = 1'b1;
            instructionAddressSource = NEXT_PC;
            next_state_s = STATE_FETCH;
          end
          ALU: begin
            rdSourceSelect.alu_output_enable = 1'b1;
            rdWriteEnable = 1'b1;
            pcWriteEnable = 1'b1;
            instructionAddressSource = NEXT_PC;
            next_state_s = STATE_FETCH;
          end
          JUMP: begin
            rdSourceSelect.branch_alu_output_enable = 1'b1;
            if (opcode == OPCODE_JALR) begin
              branchALUMode = JALR;
            end else begin
              branchALUMode = JAL;
            end
            rdWriteEnable = 1'b1;
            pcWriteEnable = 1'b1;
            instructionAddressSource = NEXT_PC;
            next_state_s = STATE_FETCH;
          end
          BRANCH_CLASS: begin
            branchALUMode = BRANCH;
            pcWriteEnable = 1'b1;
            instructionAddressSource = NEXT_PC;
            next_state_s = STATE_FETCH;
          end
          NOP_CLASS: begin
            pcWriteEnable = 1'b1;
            instructionAddressSource = NEXT_PC;
            next_state_s = STATE_FETCH;
          end
          LOAD_CLASS: begin
            memoryMode = LOAD;
            load_count_s = 1'b1;
            next_state_s = STATE_MEM_WAIT;
          end
          STORE_CLASS: begin
            memoryMode = STORE_PRELOAD;
            load_count_s = 1'b1;
            next_state_s = STATE_STORE_PRELOAD;
          end
          HALT_CLASS: begin
            set_halt_s = 1'b1;
            next_state_s = STATE_HALT;
          end
          default: begin
            set_halt_s = 1'b1;
            set_illegal_s = 1'b1;
            next_state_s = STATE_HALT;
          end
        endcase
      end
      STATE_MEM_WAIT: begin
        memoryMode = LOAD;
        // The last wait cycle doubles as the load's commit cycle.
        if (count_r == 4'd1) begin
          rdSourceSelect.memory_output_enable = 1'b1;
          rdWriteEnable = 1'b1;
          pcWriteEnable = 1'b1;
          instructionAddressSource = NEXT_PC;
          next_state_s = STATE_FETCH;
        end else begin
          next_state_s = STATE_MEM_WAIT;
        end
      end
      STATE_STORE_PRELOAD: begin
        memoryMode = STORE_PRELOAD;
        if (count_r == 4'd1) begin
          next_state_s = STATE_STORE_COMMIT;
        end else begin
          next_state_s = STATE_STORE_PRELOAD;
        end
      end
      STATE_STORE_COMMIT: begin
        memoryMode = STORE;
        pcWriteEnable = 1'b1;
        instructionAddressSource = NEXT_PC;
        next_state_s = STATE_FETCH;
      end
      STATE_HALT: next_state_s = STATE_HALT;
      default:    next_state_s = STATE_FETCH;
    endcase
  end

  // State, latency counter, sticky flags and retirement count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= STATE_FETCH;
      count_r   <= 4'd0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      instret_r <= 64'd0;
    end else begin
      state_r <= next_state_s;
      if (load_count_s) begin
        count_r <= LATENCY_LOAD;
      end else if (count_r != 4'd0) begin
        count_r <= count_r - 4'd1;
      end else begin
        count_r <= count_r;
      end
      halted_r  <= halted_r | set_halt_s;
      illegal_r <= illegal_r | set_illegal_s;
      if (pcWriteEnable) begin
        instret_r <= instret_r + 64'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign halted             = halted_r;
  assign illegalInstruction = illegal_r;
  assign instretCount       = instret_r;

endmodule

// File: tb/tb_core_control_fsm.sv
// Randomized bench for core_control_fsm at memory latencies 1, 3 and 4; each
// instruction is expanded into its expected per-cycle output trace.
module tb_core_control_fsm;
  import core_control_fsm_pkg::*;

  logic                      clock;
  logic                      reset [3];
  logic [6:0]                opcode [3];
  logic [2:0]                funct3 [3];
  MemoryMode_t               memoryMode [3];
  BranchALUMode_t            branchALUMode [3];
  ImmediateFormerMode_t      immediateFormerMode [3];
  RDSourceSelectLines_t      rdSourceSelect [3];
  logic                      rdWriteEnable [3];
  logic                      pcWriteEnable [3];
  InstructionAddressSource_t instructionAddressSource [3];
  logic                      halted [3];
  logic                      illegalInstruction [3];
  logic [63:0]               instretCount [3];

  int          n_run = 0;
  int          n_fail = 0;
  logic [63:0] mdl_ir [3];
  logic        mdl_halt [3];
  logic        mdl_ill [3];
  logic        pend_halt;
  logic        pend_ill;
  logic [13:0] trace [$];
  logic [13:0] obs_v;
  logic [63:0] obs_ir;

  core_control_fsm #(.MEM_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset[0]), .opcode(opcode[0]), .funct3(funct3[0]),
    .memoryMode(memoryMode[0]), .branchALUMode(branchALUMode[0]),
    .immediateFormerMode(immediateFormerMode[0]), .rdSourceSelect(rdSourceSelect[0]),
    .rdWriteEnable(rdWriteEnable[0]), .pcWriteEnable(pcWriteEnable[0]),
    .instructionAddressSource(instructionAddressSource[0]), .halted(halted[0]),
    .illegalInstruction(illegalInstruction[0]), .instretCount(instretCount[0]));

  core_control_fsm #(.MEM_LATENCY(3)) dut1 (
    .clock(clock), .reset(reset[1]), .opcode(opcode[1]), .funct3(funct3[1]),
    .memoryMode(memoryMode[1]), .branchALUMode(branchALUMode[1]),
    .immediateFormerMode(immediateFormerMode[1]), .rdSourceSelect(rdSourceSelect[1]),
    .rdWriteEnable(rdWriteEnable[1]), .pcWriteEnable(pcWriteEnable[1]),
    .instructionAddressSource(instructionAddressSource[1]), .halted(halted[1]),
    .illegalInstruction(illegalInstruction[1]), .instretCount(instretCount[1]));

  core_control_fsm #(.MEM_LATENCY(4)) dut2 (
    .clock(clock), .reset(reset[2]), .opcode(opcode[2]), .funct3(funct3[2]),
    .memoryMode(memoryMode[2]), .branchALUMode(branchALUMode[2]),
    .immediateFormerMode(immediateFormerMode[2]), .rdSourceSelect(rdSourceSelect[2]),
    .rdWriteEnable(rdWriteEnable[2]), .pcWriteEnable(pcWriteEnable[2]),
    .instructionAddressSource(instructionAddressSource[2]), .halted(halted[2]),
    .illegalInstruction(illegalInstruction[2]), .instretCount(instretCount[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [13:0] pk(input int d, input MemoryMode_t m, input BranchALUMode_t b,
                                     input ImmediateFormerMode_t i, input RDSourceSelectLines_t r,
                                     input logic we, input logic pw, input InstructionAddressSource_t a);
    return {m, b, i, r, we, pw, a, mdl_halt[d], mdl_ill[d]};
  endfunction

  function automatic logic [13:0] dflt(input int d);
    return pk(d, NOP, INCREMENT, LUI, '0, 1'b0, 1'b0, CURRENT_PC);
  endfunction

  // Expected outputs, one entry per cycle, for one instruction starting at FETCH.
  task automatic build_trace(input int d, input logic [6:0] op, input logic [2:0] f3);
    RDSourceSelectLines_t r;
    r = '0;
    pend_halt = 1'b0;
    pend_ill = 1'b0;
    trace.delete();
    trace.push_back(dflt(d));
    if (mdl_halt[d]) return;
    case (op)
      7'b0110111, 7'b0010111: begin
        r.immediate_former_output_enable = 1'b1;
        trace.push_back(pk(d, NOP, INCREMENT, (op == 7'b0010111) ? AUIPC : LUI, r, 1'b1, 1'b1, NEXT_PC));
      end
      7'b0010011, 7'b0110011: begin
        r.alu_output_enable = 1'b1;
        trace.push_back(pk(d, NOP, INCREMENT, LUI, r, 1'b1, 1'b1, NEXT_PC));
      end
      7'b1101111, 7'b1100111: begin
        r.branch_alu_output_enable = 1'b1;
        trace.push_back(pk(d, NOP, (op == 7'b1100111) ? JALR : JAL, LUI, r, 1'b1, 1'b1, NEXT_PC));
      end
      7'b1100011: trace.push_back(pk(d, NOP, BRANCH, LUI, '0, 1'b0, 1'b1, NEXT_PC));
      7'b0001111: trace.push_back(pk(d, NOP, INCREMENT, LUI, '0, 1'b0, 1'b1, NEXT_PC));
      7'b0000011: begin
        repeat (lat(d)) trace.push_back(pk(d, LOAD, INCREMENT, LUI, '0, 1'b0, 1'b0, CURRENT_PC));
        r.memory_output_enable = 1'b1;
        trace.push_back(pk(d, LOAD, INCREMENT, LUI, r, 1'b1, 1'b1, NEXT_PC));
      end
      7'b0100011: begin
        repeat (lat(d) + 1) trace.push_back(pk(d, STORE_PRELOAD, INCREMENT, LUI, '0, 1'b0, 1'b0, CURRENT_PC));
        trace.push_back(pk(d, STORE, INCREMENT, LUI, '0, 1'b0, 1'b1, NEXT_PC));
      end
      7'b1110011: begin
        trace.push_back(dflt(d));
        pend_halt = 1'b1;
        pend_ill = (f3 != 3'b000);
      end
      default: begin
        trace.push_back(dflt(d));
        pend_halt = 1'b1;
        pend_ill = 1'b1;
      end
    endcase
  endtask

  task automatic apply_pending(input int d);
    mdl_halt[d] = mdl_halt[d] | pend_halt;
    mdl_ill[d] = mdl_ill[d] | pend_ill;
  endtask

  task automatic clear_model(input int d);
    mdl_ir[d] = 64'd0;
    mdl_halt[d] = 1'b0;
    mdl_ill[d] = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; samples 1 unit after the falling edge.
  task automatic drive_sample(input int d, input logic [6:0] op, input logic [2:0] f3, input bit scramble);
    opcode[d] = scramble ? 7'($urandom) : op;
    funct3[d] = scramble ? 3'($urandom) : f3;
    #5;
    obs_v = {memoryMode[d], branchALUMode[d], immediateFormerMode[d], rdSourceSelect[d],
             rdWriteEnable[d], pcWriteEnable[d], instructionAddressSource[d], halted[d],
             illegalInstruction[d]};
    obs_ir = instretCount[d];
  endtask

  task automatic advance(input int d, input logic [13:0] ev);
    if (ev[3]) mdl_ir[d] = mdl_ir[d] + 64'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int d);
    reset[d] = 1'b0;
    @(posedge clock);
    #1;
    reset[d] = 1'b1;
    clear_model(d);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) begin
      o = 7'($urandom);
      o[1:0] = 2'($urandom_range(0, 2));
    end else if (r < 4) begin
      o = 7'b1110011;
    end else begin
      case ($urandom_range(0, 9))
        0: o = 7'b0110111;
        1: o = 7'b0010111;
        2: o = 7'b0010011;
        3: o = 7'b0110011;
        4: o = 7'b1101111;
        5: o = 7'b1100111;
        6: o = 7'b1100011;
        7: o = 7'b0001111;
        8: o = 7'b0000011;
        default: o = 7'b0100011;
      endcase
    end
    return o;
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      start(d);
      drive_sample(d, 7'd0, 3'd0, 1'b1);
      n_run++;
      if (obs_v !== dflt(d) || obs_ir !== 64'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h ir %0d, expected %h ir 0", d, obs_v, obs_ir, dflt(d));
      end
      reset[d] = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_nonmem();
    logic [6:0] ops [$];
    logic [2:0] f;
    ops = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
            7'b1100111, 7'b0001111};
    start(0);
    foreach (ops[n]) begin
      f = 3'($urandom);
      build_trace(0, ops[n], f);
      foreach (trace[k]) begin
        drive_sample(0, ops[n], f, k == 0);
        n_run++;
        if (obs_v !== trace[k] || obs_ir !== mdl_ir[0]) begin
          n_fail++;
          $display("FAIL nonmem op %b cycle %0d: got %h ir %0d, expected %h ir %0d",
                   ops[n], k, obs_v, obs_ir, trace[k], mdl_ir[0]);
        end
        advance(0, trace[k]);
      end
      apply_pending(0);
    end
  endtask

  task automatic test_jump_branch();
    logic [6:0] ops [$];
    ops = '{7'b1101111, 7'b1100011};
    start(1);
    foreach (ops[n]) begin
      build_trace(1, ops[n], 3'b000);
      foreach (trace[k]) begin
        drive_sample(1, ops[n], 3'b000, k == 0);
        n_run++;
        if (obs_v !== trace[k] || obs_ir !== mdl_ir[1]) begin
          n_fail++;
          $display("FAIL jump_branch op %b cycle %0d: got %h ir %0d, expected %h ir %0d",
                   ops[n], k, obs_v, obs_ir, trace[k], mdl_ir[1]);
        end
        advance(1, trace[k]);
      end
      apply_pending(1);
    end
    n_run++;
    if (instretCount[1] !== 64'd2) begin
      n_fail++;
      $display("FAIL jump_branch instret: got %0d, expected 2", instretCount[1]);
    end
  endtask

  task automatic test_memory();
    logic [6:0] ops [$];
    logic [2:0] f;
    ops = '{7'b0000011, 7'b0100011, 7'b0000011, 7'b0010011, 7'b0100011};
    for (int d = 0; d < 3; d++) begin
      start(d);
      foreach (ops[n]) begin
        f = 3'($urandom);
        build_trace(d, ops[n], f);
        foreach (trace[k]) begin
          drive_sample(d, ops[n], f, k == 0);
          n_run++;
          if (obs_v !== trace[k] || obs_ir !== mdl_ir[d]) begin
            n_fail++;
            $display("FAIL memory dut%0d op %b cycle %0d: got %h ir %0d, expected %h ir %0d",
                     d, ops[n], k, obs_v, obs_ir, trace[k], mdl_ir[d]);
          end
          advance(d, trace[k]);
        end
        apply_pending(d);
      end
    end
  endtask

  task automatic test_halt();
    logic [6:0] op;
    logic [2:0] f;
    logic [6:0] hop;
    logic [2:0] hf;
    for (int pass = 0; pass < 4; pass++) begin
      case (pass)
        0:       begin hop = 7'b0000000; hf = 3'b000; end
        1:       begin hop = 7'b1110011; hf = 3'b000; end
        2:       begin hop = 7'b1110011; hf = 3'b001; end
        default: begin hop = 7'b0110001; hf = 3'b000; end
      endcase
      start(0);
      for (int n = 0; n < 22; n++) begin
        op = (n == 0) ? 7'b0010011 : (n == 1) ? hop : 7'($urandom);
        f = (n == 1) ? hf : 3'($urandom);
        build_trace(0, op, f);
        foreach (trace[k]) begin
          drive_sample(0, op, f, k == 0);
          n_run++;
          if (obs_v !== trace[k] || obs_ir !== mdl_ir[0]) begin
            n_fail++;
            $display("FAIL halt pass %0d instr %0d cycle %0d: got %h ir %0d, expected %h ir %0d",
                     pass, n, k, obs_v, obs_ir, trace[k], mdl_ir[0]);
          end
          advance(0, trace[k]);
        end
        apply_pending(0);
      end
      n_run++;
      if (halted[0] !== 1'b1 || illegalInstruction[0] !== (pass != 1) || instretCount[0] !== 64'd1) begin
        n_fail++;
        $display("FAIL halt_final pass %0d: got halted %b illegal %b ir %0d, expected 1 %b 1",
                 pass, halted[0], illegalInstruction[0], instretCount[0], pass != 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    start(2);
    build_trace(2, 7'b0010011, 3'b000);
    foreach (trace[k]) begin
      drive_sample(2, 7'b0010011, 3'b000, k == 0);
      n_run++;
      if (obs_v !== trace[k] || obs_ir !== mdl_ir[2]) begin
        n_fail++;
        $display("FAIL abort_pre cycle %0d: got %h ir %0d, expected %h ir %0d",
                 k, obs_v, obs_ir, trace[k], mdl_ir[2]);
      end
      advance(2, trace[k]);
    end
    build_trace(2, 7'b0000011, 3'b010);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) reset[2] = 1'b0;
      drive_sample(2, 7'b0000011, 3'b010, k == 0);
      n_run++;
      if (obs_v !== trace[k] || obs_ir !== mdl_ir[2]) begin
        n_fail++;
        $display("FAIL abort_load cycle %0d: got %h ir %0d, expected %h ir %0d",
                 k, obs_v, obs_ir, trace[k], mdl_ir[2]);
      end
      advance(2, trace[k]);
    end
    reset[2] = 1'b1;
    clear_model(2);
    build_trace(2, 7'b0010011, 3'b000);
    foreach (trace[k]) begin
      drive_sample(2, 7'b0010011, 3'b000, k == 0);
      n_run++;
      if (obs_v !== trace[k] || obs_ir !== mdl_ir[2]) begin
        n_fail++;
        $display("FAIL abort_post cycle %0d: got %h ir %0d, expected %h ir %0d",
                 k, obs_v, obs_ir, trace[k], mdl_ir[2]);
      end
      advance(2, trace[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [2:0] f;
    for (int d = 0; d < 3; d++) begin
      start(d);
      for (int n = 0; n < 40; n++) begin
        op = pick_op();
        f = 3'($urandom);
        build_trace(d, op, f);
        foreach (trace[k]) begin
          drive_sample(d, op, f, k == 0);
          n_run++;
          if (obs_v !== trace[k] || obs_ir !== mdl_ir[d]) begin
            n_fail++;
            $display("FAIL random dut%0d instr %0d op %b f3 %b cycle %0d: got %h ir %0d, expected %h ir %0d",
                     d, n, op, f, k, obs_v, obs_ir, trace[k], mdl_ir[d]);
          end
          advance(d, trace[k]);
        end
        apply_pending(d);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b0;
      opcode[d] = 7'd0;
      funct3[d] = 3'd0;
      clear_model(d);
    end
    pend_halt = 1'b0;
    pend_ill = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_nonmem();
    test_jump_branch();
    test_memory();
    test_halt();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
